// File: rtl/mem_imm_unit.sv
// Instruction ROM, data RAM with preset reset image, and RISC-V immediate generator.
// Reads are combinational; data RAM writes are synchronous; reset is async active-high.
module mem_imm_unit #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [31:0]       instr,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out,
   input  logic [31:0]       imm_inst,
   output logic [31:0]       imm_out
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0] mem [DEPTH];
   logic        unused_bits;

   assign unused_bits = ^imm_inst[1:0];

   // Fixed program: two loads, an add, and a store; the rest are nops.
   always_comb begin
      instr = 32'h0000_0033;
      case (inst_addr)
         ADDR_W'(0): instr = 32'h0000_2083;
         ADDR_W'(1): instr = 32'h0040_2103;
         ADDR_W'(2): instr = 32'h0020_81B3;
         ADDR_W'(3): instr = 32'h0030_2423;
         default:    instr = 32'h0000_0033;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         mem[0] <= 32'd17;
         mem[1] <= 32'd9;
         mem[2] <= 32'd25;
      end else if (mem_write) begin
         mem[data_addr] <= data_in;
      end
   end

   assign data_out = mem_read ? mem[data_addr] : '0;

   // B and J immediates stay in halfword units; the datapath adds the implicit zero LSB.
   always_comb begin
      imm_out = '0;
      case (imm_inst[6:2])
         5'b00000, 5'b00100, 5'b11001:
            imm_out = {{20{imm_inst[31]}}, imm_inst[31:20]};
         5'b01000:
            imm_out = {{20{imm_inst[31]}}, imm_inst[31:25], imm_inst[11:7]};
         5'b11000:
            imm_out = {{20{imm_inst[31]}}, imm_inst[31], imm_inst[7],
                       imm_inst[30:25], imm_inst[11:8]};
         5'b11011:
            imm_out = {{12{imm_inst[31]}}, imm_inst[31], imm_inst[19:12],
                       imm_inst[20], imm_inst[30:21]};
         5'b01101, 5'b00101:
            imm_out = {imm_inst[31:12], 12'b0};
         default:
            imm_out = '0;
      endcase
   end

endmodule

// File: tb/tb_mem_imm_unit.sv
// Directed self-checking bench for mem_imm_unit: ROM contents, RAM reset image,
// write/read behaviour, reset override of writes, and immediate decoding.
module tb_mem_imm_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  inst_addr;
   logic [31:0] instr;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  data_addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic [31:0] imm_inst;
   logic [31:0] imm_out;

   int n_pass = 0;
   int n_total = 0;

   mem_imm_unit #(.ADDR_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .inst_addr (inst_addr),
      .instr     (instr),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .data_addr (data_addr),
      .data_in   (data_in),
      .data_out  (data_out),
      .imm_inst  (imm_inst),
      .imm_out   (imm_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [5:0] a, input string tag, input logic [31:0] exp);
      data_addr = a;
      mem_read  = 1'b1;
      #1;
      check(tag, data_out, exp);
   endtask

   task automatic fetch(input logic [5:0] a, input string tag, input logic [31:0] exp);
      inst_addr = a;
      #1;
      check(tag, instr, exp);
   endtask

   task automatic imm(input logic [31:0] ins, input string tag, input logic [31:0] exp);
      imm_inst = ins;
      #1;
      check(tag, imm_out, exp);
   endtask

   initial begin
      rst = 1'b0; inst_addr = '0; mem_read = 1'b0; mem_write = 1'b0;
      data_addr = '0; data_in = '0; imm_inst = '0;
      #2 rst = 1'b1;
      #1;
      fetch(6'd1, "instr_during_rst", 32'h0040_2103);
      tick();
      @(negedge clk);
      rst = 1'b0;

      rd(6'd0, "rst_w0", 32'd17);
      rd(6'd1, "rst_w1", 32'd9);
      rd(6'd2, "rst_w2", 32'd25);
      rd(6'd5, "rst_w5", 32'd0);

      fetch(6'd0,  "rom_0",  32'h0000_2083);
      fetch(6'd1,  "rom_1",  32'h0040_2103);
      fetch(6'd2,  "rom_2",  32'h0020_81B3);
      fetch(6'd3,  "rom_3",  32'h0030_2423);
      fetch(6'd10, "rom_10", 32'h0000_0033);
      fetch(6'd63, "rom_63", 32'h0000_0033);

      // Write 26 to addr 2 with read enabled: old value before the edge, new after.
      @(negedge clk);
      data_addr = 6'd2; data_in = 32'h0000_001A; mem_write = 1'b1; mem_read = 1'b1;
      #1 check("rdw_before", data_out, 32'd25);
      tick();
      check("rdw_after", data_out, 32'd26);
      @(negedge clk);
      mem_write = 1'b0;
      rd(6'd2, "wr_readback", 32'd26);
      mem_read = 1'b0;
      #1 check("read_disabled", data_out, 32'd0);

      // Last address, full range.
      @(negedge clk);
      data_addr = 6'd63; data_in = 32'hA5A5_5A5A; mem_write = 1'b1;
      tick();
      @(negedge clk);
      mem_write = 1'b0;
      rd(6'd63, "wr_addr63", 32'hA5A5_5A5A);
      rd(6'd0, "addr0_untouched", 32'd17);

      // Mid-cycle reset restores the image immediately.
      @(negedge clk);
      data_addr = 6'd2; mem_read = 1'b1;
      #1 rst = 1'b1;
      #1 check("async_rst_w2", data_out, 32'd25);
      rd(6'd63, "async_rst_w63", 32'd0);

      // Writes during reset are ignored.
      data_addr = 6'd0; data_in = 32'hDEAD_BEEF; mem_write = 1'b1;
      tick();
      @(negedge clk);
      rst = 1'b0; mem_write = 1'b0;
      rd(6'd0, "wr_during_rst", 32'd17);

      imm(32'hFFC0_0093, "imm_addi", 32'hFFFF_FFFC);
      imm(32'h0030_2423, "imm_sw",   32'h0000_0008);
      imm(32'h1234_50B7, "imm_lui",  32'h1234_5000);
      imm(32'hFE00_0EE3, "imm_beq",  32'hFFFF_FFFE);
      imm(32'h0080_006F, "imm_jal",  32'h0000_0004);
      imm(32'h0020_81B3, "imm_rtype", 32'h0000_0000);
      imm(32'h8000_0067, "imm_jalr_neg", 32'hFFFF_F800);
      imm(32'hFFFF_F017, "imm_auipc", 32'hFFFF_F000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
